// File: rtl/haraka_aes_round_pipe.sv
// Haraka v2 multi-lane keyed AES round pipeline, one register stage per round.
// Define HARAKA_AES_PIPE_LAST_NOMIX_EN to drop MixColumns from the final round.
module haraka_aes_round_pipe #(
    parameter int LANES  = 4,
    parameter int ROUNDS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*128-1:0]    in_msg,
    input  logic [ROUNDS*LANES*128-1:0] in_keys,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*128-1:0]    out_data,
    output logic                    busy
);

    localparam int LW = LANES * 128;
    localparam int KW = ROUNDS * LW;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One keyed AES round on a single 128-bit column-major lane.
    function automatic logic [127:0] aes_round(
        input logic [127:0] s,
        input logic [127:0] k,
        input logic         mix
    );
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            b[i] = SBOX[s[i*8 +: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            if (mix) begin
                o[(4*c)*8   +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                o[(4*c+1)*8 +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                o[(4*c+2)*8 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                o[(4*c+3)*8 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
                o[(4*c)*8   +: 8] = a0;
                o[(4*c+1)*8 +: 8] = a1;
                o[(4*c+2)*8 +: 8] = a2;
                o[(4*c+3)*8 +: 8] = a3;
            end
        end
        return o ^ k;
    endfunction

    logic [ROUNDS-1:0] vld;
    logic [LW-1:0]     st_q [ROUNDS];
    logic [KW-1:0]     kq   [ROUNDS];
    logic [LW-1:0]     prev [ROUNDS];
    logic [KW-1:0]     kin  [ROUNDS];
    logic [LW-1:0]     nxt  [ROUNDS];
    logic [ROUNDS:0]   sv;
    logic [ROUNDS:0]   adx;

    // Per-stage round datapath; keys for later rounds ride down the pipe.
    always_comb begin
        logic mix;
        for (int r = 0; r < ROUNDS; r++) begin
            prev[r] = '0;
            kin[r]  = '0;
            nxt[r]  = '0;
        end
        prev[0] = in_msg;
        kin[0]  = in_keys;
        for (int r = 1; r < ROUNDS; r++) begin
            prev[r] = st_q[r-1];
            kin[r]  = kq[r-1];
        end
        for (int r = 0; r < ROUNDS; r++) begin
`ifdef HARAKA_AES_PIPE_LAST_NOMIX_EN
            mix = (r != ROUNDS - 1);
`else
            mix = 1'b1;
`endif
            for (int l = 0; l < LANES; l++)
                nxt[r][l*128 +: 128] = aes_round(prev[r][l*128 +: 128],
                                                 kin[r][l*128 +: 128], mix);
        end
    end

    // Advance chain resolved from the output back; adx[r] = stage r loads.
    always_comb begin
        sv  = {vld, in_valid};
        adx = '0;
        adx[ROUNDS] = out_ready;
        for (int r = ROUNDS - 1; r >= 0; r--)
            adx[r] = sv[r] && (!vld[r] || adx[r+1]);
    end

    // Stage registers: load on advance, clear valid when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int r = 0; r < ROUNDS; r++) begin
                st_q[r] <= '0;
                kq[r]   <= '0;
            end
        end else begin
            for (int r = 0; r < ROUNDS; r++) begin
                if (adx[r]) begin
                    st_q[r] <= nxt[r];
                    kq[r]   <= kin[r] >> LW;
                    vld[r]  <= 1'b1;
                end else if (adx[r+1]) begin
                    vld[r]  <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = !vld[0] || adx[1];
    assign out_valid = vld[ROUNDS-1];
    assign out_data  = st_q[ROUNDS-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_haraka_aes_round_pipe.sv
// Self-checking bench for haraka_aes_round_pipe: FIPS vector, lane isolation,
// streaming, backpressure and async reset, with a scoreboard against a model.
module tb_haraka_aes_round_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, out_valid, out_ready, busy;
    logic [511:0]    in_msg, out_data;
    logic [1023:0]   in_keys;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0]    a_in_msg, a_in_keys, a_out_data;

    haraka_aes_round_pipe #(.LANES(4), .ROUNDS(2)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_msg(in_msg), .in_keys(in_keys),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    haraka_aes_round_pipe #(.LANES(1), .ROUNDS(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_msg(a_in_msg), .in_keys(a_in_keys),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .busy(a_busy)
    );

    int errors = 0;
    int checks = 0;
    logic [511:0] sb [$];
    logic [7:0]   sbt [256];

    localparam logic [127:0] FIPS_MSG = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] FIPS_KEY = 128'h05766c2a3939a323b12c548817fefaa0;
`ifdef HARAKA_AES_PIPE_LAST_NOMIX_EN
    localparam logic [127:0] FIPS_OUT = 128'he0ee4b34c828e29b1f7ee06827a34574;
`else
    localparam logic [127:0] FIPS_OUT = 128'h49506a0243ea5b6b2b359f68f27f9ca4;
`endif

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                   ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] m_round(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input bit mix);
        logic [7:0] st [4][4];
        logic [7:0] sh [4][4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) st[i%4][i/4] = sbt[s[i*8 +: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) sh[r][c] = st[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (mix)
                    o[(4*c+r)*8 +: 8] = gmul(8'h02, sh[r][c])
                                      ^ gmul(8'h03, sh[(r+1)%4][c])
                                      ^ sh[(r+2)%4][c] ^ sh[(r+3)%4][c];
                else
                    o[(4*c+r)*8 +: 8] = sh[r][c];
            end
        return o ^ k;
    endfunction

    function automatic logic [511:0] model4(input logic [511:0] m,
                                            input logic [1023:0] k);
        logic [511:0] o;
        for (int l = 0; l < 4; l++) begin
            logic [127:0] s = m[l*128 +: 128];
            for (int r = 0; r < 2; r++) begin
`ifdef HARAKA_AES_PIPE_LAST_NOMIX_EN
                s = m_round(s, k[(r*4+l)*128 +: 128], r != 1);
`else
                s = m_round(s, k[(r*4+l)*128 +: 128], 1'b1);
`endif
            end
            o[l*128 +: 128] = s;
        end
        return o;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive one cycle on u4, report handshakes, push expected on accept.
    task automatic step4(input logic v, input logic [511:0] m,
                         input logic [1023:0] k, input logic ordy,
                         output logic acc, output logic emit,
                         output logic [511:0] d);
        @(negedge clk);
        in_valid  = v;
        in_msg    = m;
        in_keys   = k;
        out_ready = ordy;
        #1;
        acc  = v && in_ready;
        emit = out_valid && out_ready;
        d    = out_data;
        if (acc) sb.push_back(model4(m, k));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (out_data !== '0) begin errors++;
            $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== '0) begin errors++;
            $display("FAIL reset_u1 got=%b/%h want=0/0", a_out_valid, a_out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset busy=%b ov=%b want=0/0", busy, out_valid); end
    endtask

    task automatic test_fips_vector();
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_msg   = FIPS_MSG;
        a_in_keys  = FIPS_KEY;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++;
            $display("FAIL fips_in_ready got=%b want=1", a_in_ready); end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b1) begin errors++;
            $display("FAIL fips_latency out_valid=%b want=1", a_out_valid); end
        checks++; if (a_out_data !== FIPS_OUT) begin errors++;
            $display("FAIL fips_data got=%h want=%h", a_out_data, FIPS_OUT); end
`ifdef HARAKA_AES_PIPE_LAST_NOMIX_EN
        checks++; if (a_out_data !== m_round(FIPS_MSG, FIPS_KEY, 1'b0)) begin errors++;
`else
        checks++; if (a_out_data !== m_round(FIPS_MSG, FIPS_KEY, 1'b1)) begin errors++;
`endif
            $display("FAIL fips_model got=%h", a_out_data); end
        @(negedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin errors++;
            $display("FAIL fips_single ov=%b busy=%b want=0/0", a_out_valid, a_busy); end
    endtask

    task automatic test_zero();
        logic acc, emit;
        logic [511:0] d, exp;
        step4(1'b1, '0, '0, 1'b1, acc, emit, d);
        checks++; if (acc !== 1'b1) begin errors++;
            $display("FAIL zero_accept got=%b want=1", acc); end
        step4(1'b0, '0, '0, 1'b1, acc, emit, d);
        checks++; if (emit !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL zero_mid emit=%b busy=%b want=0/1", emit, busy); end
        step4(1'b0, '0, '0, 1'b1, acc, emit, d);
        checks++; if (emit !== 1'b1) begin errors++;
            $display("FAIL zero_latency emit=%b want=1", emit); end
        exp = sb.pop_front();
        checks++; if (d !== {64{8'hfb}}) begin errors++;
            $display("FAIL zero_data got=%h want=all fb", d); end
        checks++; if (d !== exp) begin errors++;
            $display("FAIL zero_model got=%h want=%h", d, exp); end
    endtask

    task automatic test_lane_isolation();
        logic acc, emit;
        logic [511:0] m, d, exp;
        bit done = 0;
        m = '0;
        m[2*128 +: 128] = FIPS_MSG;
        step4(1'b1, m, '0, 1'b1, acc, emit, d);
        for (int i = 0; i < 6 && !done; i++) begin
            step4(1'b0, '0, '0, 1'b1, acc, emit, d);
            if (emit) begin
                done = 1;
                exp = sb.pop_front();
                for (int l = 0; l < 4; l++) begin
                    checks++;
                    if (l != 2 && d[l*128 +: 128] !== {16{8'hfb}}) begin errors++;
                        $display("FAIL iso_lane%0d got=%h want=all fb", l, d[l*128 +: 128]); end
                    else if (l == 2 && d[l*128 +: 128] !== exp[l*128 +: 128]) begin errors++;
                        $display("FAIL iso_lane2 got=%h want=%h", d[l*128 +: 128], exp[l*128 +: 128]); end
                end
                checks++; if (d[2*128 +: 128] === {16{8'hfb}}) begin errors++;
                    $display("FAIL iso_lane2_differs got=%h want!=all fb", d[2*128 +: 128]); end
            end
        end
        checks++; if (!done) begin errors++;
            $display("FAIL iso_timeout got=no output want=output"); end
    endtask

    task automatic test_back_to_back();
        logic acc, emit;
        logic [511:0] d, exp;
        int sent = 0, got = 0, last = 0;
        for (int cyc = 0; cyc < 30 && (sent < 10 || sb.size() > 0); cyc++) begin
            if (sent < 10) begin
                step4(1'b1, rnd512(), rnd1024(), 1'b1, acc, emit, d);
                checks++; if (acc !== 1'b1) begin errors++;
                    $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, acc); end
                if (acc) sent++;
            end else begin
                step4(1'b0, '0, '0, 1'b1, acc, emit, d);
            end
            if (emit) begin
                exp = sb.pop_front();
                checks++; if (d !== exp) begin errors++;
                    $display("FAIL b2b_data n=%0d got=%h want=%h", got, d, exp); end
                if (got > 0 && cyc != last + 1) begin errors++;
                    $display("FAIL b2b_gap n=%0d cyc=%0d want=%0d", got, cyc, last + 1); end
                checks++;
                last = cyc;
                got++;
            end
        end
        checks++; if (got != 10) begin errors++;
            $display("FAIL b2b_count got=%0d want=10", got); end
    endtask

    task automatic test_backpressure();
        logic acc, emit;
        logic [511:0] d, exp;
        int got = 0;
        for (int i = 0; i < 3; i++)
            step4(1'b1, rnd512(), rnd1024(), 1'b0, acc, emit, d);
        checks++; if (sb.size() != 2) begin errors++;
            $display("FAIL bp_fill got=%0d want=2", sb.size()); end
        for (int i = 0; i < 5; i++) begin
            step4(1'b1, rnd512(), rnd1024(), 1'b0, acc, emit, d);
            checks++; if (in_ready !== 1'b0 || acc !== 1'b0) begin errors++;
                $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || d !== sb[0]) begin errors++;
                $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, d, sb[0]); end
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            step4(1'b0, '0, '0, 1'b1, acc, emit, d);
            if (emit) begin
                exp = sb.pop_front();
                checks++; if (d !== exp) begin errors++;
                    $display("FAIL bp_drain n=%0d got=%h want=%h", got, d, exp); end
                got++;
            end
        end
        step4(1'b0, '0, '0, 1'b1, acc, emit, d);
        checks++; if (got != 2 || emit !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL bp_count got=%0d extra=%b busy=%b want=2/0/0", got, emit, busy); end
        sb.delete();
    endtask

    task automatic test_reset_midflight();
        logic acc, emit;
        logic [511:0] d, exp, m;
        logic [1023:0] k;
        step4(1'b1, rnd512(), rnd1024(), 1'b0, acc, emit, d);
        step4(1'b1, rnd512(), rnd1024(), 1'b0, acc, emit, d);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rst_mid ov=%b busy=%b want=0/0", out_valid, busy); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        m = rnd512();
        k = rnd1024();
        step4(1'b1, m, k, 1'b1, acc, emit, d);
        checks++; if (acc !== 1'b1) begin errors++;
            $display("FAIL rst_accept got=%b want=1", acc); end
        step4(1'b0, '0, '0, 1'b1, acc, emit, d);
        checks++; if (emit !== 1'b0) begin errors++;
            $display("FAIL rst_early got=%b want=0", emit); end
        step4(1'b0, '0, '0, 1'b1, acc, emit, d);
        checks++; if (emit !== 1'b1) begin errors++;
            $display("FAIL rst_latency got=%b want=1", emit); end
        exp = model4(m, k);
        checks++; if (d !== exp) begin errors++;
            $display("FAIL rst_data got=%h want=%h", d, exp); end
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_msg = '0; in_keys = '0; out_ready = 1'b0;
        a_in_valid = 1'b0; a_in_msg = '0; a_in_keys = '0; a_out_ready = 1'b1;
        build_sbox();
        repeat (2) @(negedge clk);
        test_reset();
        test_fips_vector();
        test_zero();
        test_lane_isolation();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
